// File: rtl/ifu_fetch_queue_if.sv
// Handshake and bus bundle between the instruction fetch unit and its neighbours:
// the fetch-PC source, the MMU, instruction memory and the decode stage.
interface ifu_fetch_queue_if #(
  parameter int XLEN = 32
);
  logic            flush_i;
  logic [XLEN-1:0] pc_i;
  logic            pc_valid_i;
  logic            pc_ready_o;
  logic            mmu_en_i;
  logic            xlate_req_o;
  logic [XLEN-1:0] xlate_vaddr_o;
  logic            xlate_resp_valid_i;
  logic [XLEN-1:0] xlate_paddr_i;
  logic            xlate_fault_i;
  logic            mem_req_o;
  logic [XLEN-1:0] mem_addr_o;
  logic            mem_rvalid_i;
  logic [31:0]     mem_rdata_i;
  logic            out_valid_o;
  logic            out_ready_i;
  logic [XLEN-1:0] out_pc_o;
  logic [31:0]     out_inst_o;
  logic            out_rvc_o;
  logic [XLEN-1:0] out_next_pc_o;
  logic            out_pf_o;
  logic            busy_o;

  // Fetch unit side.
  modport slave (
    input  flush_i, pc_i, pc_valid_i, mmu_en_i,
           xlate_resp_valid_i, xlate_paddr_i, xlate_fault_i,
           mem_rvalid_i, mem_rdata_i, out_ready_i,
    output pc_ready_o, xlate_req_o, xlate_vaddr_o, mem_req_o, mem_addr_o,
           out_valid_o, out_pc_o, out_inst_o, out_rvc_o, out_next_pc_o,
           out_pf_o, busy_o
  );

  // Environment side: PC source, MMU, memory and decode.
  modport master (
    output flush_i, pc_i, pc_valid_i, mmu_en_i,
           xlate_resp_valid_i, xlate_paddr_i, xlate_fault_i,
           mem_rvalid_i, mem_rdata_i, out_ready_i,
    input  pc_ready_o, xlate_req_o, xlate_vaddr_o, mem_req_o, mem_addr_o,
           out_valid_o, out_pc_o, out_inst_o, out_rvc_o, out_next_pc_o,
           out_pf_o, busy_o
  );
endinterface

// File: rtl/ifu_fetch_queue.sv
// Single-outstanding instruction fetch engine (optional translation, then memory
// read) feeding a circular fetch queue that presents decoded-length head info.
module ifu_fetch_queue #(
  parameter int XLEN     = 32,
  parameter int FQ_DEPTH = 4   // power of two, >= 2
) (
  input logic               clk,
  input logic               rst_n,
  ifu_fetch_queue_if.slave  fq
);

  localparam int PTR_W = $clog2(FQ_DEPTH);
  localparam int CNT_W = $clog2(FQ_DEPTH) + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FQ_DEPTH);

  typedef enum logic [1:0] {IDLE, XLATE, MEM, KILL} state_t;

  state_t          state_q, state_d;
  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] paddr_q, paddr_d;
  logic            load_paddr;
  logic            kill_xlate_q, kill_xlate_d;   // which request is still open in KILL

  logic            pc_ready;
  logic            accept;
  logic            push;
  logic [31:0]     push_inst;
  logic            push_pf;
  logic            pop;

  logic [XLEN-1:0] pc_mem   [FQ_DEPTH];
  logic [31:0]     inst_mem [FQ_DEPTH];
  logic            pf_mem   [FQ_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q;

  logic            head_valid;
  logic [XLEN-1:0] head_pc;
  logic [31:0]     head_inst;
  logic            head_pf;
  logic            head_rvc;

  assign pc_ready = (state_q == IDLE) && (count_q != DEPTH_C) && !fq.flush_i;
  assign accept   = fq.pc_valid_i && pc_ready;

  // Fetch sequencing
  always_comb begin
    // NOTE: every output of this block gets a default first so no path can infer a latch.
    state_d      = state_q;
    kill_xlate_d = kill_xlate_q;
    load_paddr   = 1'b0;
    paddr_d      = fq.xlate_paddr_i;
    push         = 1'b0;
    push_inst    = '0;
    push_pf      = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          if (fq.mmu_en_i) begin
            state_d = XLATE;
          end else begin
            state_d    = MEM;
            load_paddr = 1'b1;
            paddr_d    = fq.pc_i;
          end
        end
      end

      XLATE: begin
        if (fq.flush_i) begin
          state_d      = fq.xlate_resp_valid_i ? IDLE : KILL;
          kill_xlate_d = 1'b1;
        end else if (fq.xlate_resp_valid_i) begin
          if (fq.xlate_fault_i) begin
            push    = 1'b1;
            push_pf = 1'b1;
            state_d = IDLE;
          end else begin
            load_paddr = 1'b1;
            state_d    = MEM;
          end
        end
      end

      MEM: begin
        if (fq.flush_i) begin
          state_d      = fq.mem_rvalid_i ? IDLE : KILL;
          kill_xlate_d = 1'b0;
        end else if (fq.mem_rvalid_i) begin
          push      = 1'b1;
          push_inst = fq.mem_rdata_i;
          state_d   = IDLE;
        end
      end

      KILL: begin
        // The open request must still be answered; its response is dropped.
        if (kill_xlate_q ? fq.xlate_resp_valid_i : fq.mem_rvalid_i) begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (!rst_n) begin
      state_q      <= IDLE;
      pc_q         <= '0;
      paddr_q      <= '0;
      kill_xlate_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      kill_xlate_q <= kill_xlate_d;
      if (accept) begin
        pc_q <= fq.pc_i;
      end
      if (load_paddr) begin
        paddr_q <= paddr_d;
      end
    end
  end

  assign fq.pc_ready_o    = pc_ready;
  assign fq.busy_o        = (state_q != IDLE);
  assign fq.xlate_req_o   = (state_q == XLATE) || ((state_q == KILL) && kill_xlate_q);
  assign fq.mem_req_o     = (state_q == MEM)   || ((state_q == KILL) && !kill_xlate_q);
  assign fq.xlate_vaddr_o = pc_q;
  assign fq.mem_addr_o    = paddr_q;

  // Fetch queue
  assign pop = head_valid && fq.out_ready_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (fq.flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      unique case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // NOTE: entry storage is deliberately not reset; the head is masked by count instead.
  always_ff @(posedge clk) begin
    if (push && !fq.flush_i) begin
      pc_mem[wr_ptr_q]   <= pc_q;
      inst_mem[wr_ptr_q] <= push_inst;
      pf_mem[wr_ptr_q]   <= push_pf;
    end
  end

  assign head_valid = (count_q != '0);
  assign head_pc    = head_valid ? pc_mem[rd_ptr_q]   : '0;
  assign head_inst  = head_valid ? inst_mem[rd_ptr_q] : '0;
  assign head_pf    = head_valid && pf_mem[rd_ptr_q];
  assign head_rvc   = head_valid && (head_inst[1:0] != 2'b11) && !head_pf;

  assign fq.out_valid_o   = head_valid;
  assign fq.out_pc_o      = head_pc;
  assign fq.out_inst_o    = head_inst;
  assign fq.out_pf_o      = head_pf;
  assign fq.out_rvc_o     = head_rvc;
  assign fq.out_next_pc_o = head_valid ? head_pc + (head_rvc ? XLEN'(2) : XLEN'(4)) : '0;

endmodule

// File: tb/tb_ifu_fetch_queue.sv
// Bench for ifu_fetch_queue: directed scenarios plus a randomized run checked
// against a transaction-level queue model.
module tb_ifu_fetch_queue;

  localparam int XLEN  = 32;
  localparam int DEPTH = 4;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_pass;

  ifu_fetch_queue_if #(.XLEN(XLEN)) fq ();

  ifu_fetch_queue #(.XLEN(XLEN), .FQ_DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .fq    (fq.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Every task starts and ends one time unit after a rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    fq.flush_i = 0; fq.pc_i = '0; fq.pc_valid_i = 0; fq.mmu_en_i = 0;
    fq.xlate_resp_valid_i = 0; fq.xlate_paddr_i = '0; fq.xlate_fault_i = 0;
    fq.mem_rvalid_i = 0; fq.mem_rdata_i = '0; fq.out_ready_i = 0;
    #3;
    n_checks++; if (fq.busy_o !== 1'b0) $display("FAIL reset_busy: got %0h want 0", fq.busy_o); else n_pass++;
    n_checks++; if (fq.xlate_req_o !== 1'b0) $display("FAIL reset_xlate_req: got %0h want 0", fq.xlate_req_o); else n_pass++;
    n_checks++; if (fq.mem_req_o !== 1'b0) $display("FAIL reset_mem_req: got %0h want 0", fq.mem_req_o); else n_pass++;
    n_checks++; if (fq.out_valid_o !== 1'b0) $display("FAIL reset_out_valid: got %0h want 0", fq.out_valid_o); else n_pass++;
    n_checks++; if (fq.out_pf_o !== 1'b0) $display("FAIL reset_pf: got %0h want 0", fq.out_pf_o); else n_pass++;
    n_checks++; if (fq.xlate_vaddr_o !== '0) $display("FAIL reset_vaddr: got %h want 0", fq.xlate_vaddr_o); else n_pass++;
    n_checks++; if (fq.mem_addr_o !== '0) $display("FAIL reset_mem_addr: got %h want 0", fq.mem_addr_o); else n_pass++;
    n_checks++; if (fq.out_pc_o !== '0) $display("FAIL reset_out_pc: got %h want 0", fq.out_pc_o); else n_pass++;
    n_checks++; if (fq.out_inst_o !== '0) $display("FAIL reset_out_inst: got %h want 0", fq.out_inst_o); else n_pass++;
    n_checks++; if (fq.out_next_pc_o !== '0) $display("FAIL reset_next_pc: got %h want 0", fq.out_next_pc_o); else n_pass++;
    n_checks++; if (fq.pc_ready_o !== 1'b1) $display("FAIL reset_pc_ready: got %0h want 1", fq.pc_ready_o); else n_pass++;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_nommu();
    fq.mmu_en_i = 0; fq.pc_i = 32'h8000_0000; fq.pc_valid_i = 1;
    n_checks++; if (fq.pc_ready_o !== 1'b1) $display("FAIL nommu_ready: got %0h want 1", fq.pc_ready_o); else n_pass++;
    step();                                   // cycle N+1
    fq.pc_valid_i = 0; fq.mmu_en_i = 1;       // late mmu change must not matter
    n_checks++; if (fq.mem_req_o !== 1'b1) $display("FAIL nommu_mem_req: got %0h want 1", fq.mem_req_o); else n_pass++;
    n_checks++; if (fq.mem_addr_o !== 32'h8000_0000) $display("FAIL nommu_mem_addr: got %h want 80000000", fq.mem_addr_o); else n_pass++;
    n_checks++; if (fq.xlate_req_o !== 1'b0) $display("FAIL nommu_xlate_req: got %0h want 0", fq.xlate_req_o); else n_pass++;
    n_checks++; if (fq.out_valid_o !== 1'b0) $display("FAIL nommu_early_valid: got %0h want 0", fq.out_valid_o); else n_pass++;
    fq.mem_rvalid_i = 1; fq.mem_rdata_i = 32'h0000_0413;
    step();                                   // cycle N+2
    fq.mem_rvalid_i = 0;
    n_checks++; if (fq.out_valid_o !== 1'b1) $display("FAIL nommu_valid: got %0h want 1", fq.out_valid_o); else n_pass++;
    n_checks++; if (fq.out_pc_o !== 32'h8000_0000) $display("FAIL nommu_pc: got %h want 80000000", fq.out_pc_o); else n_pass++;
    n_checks++; if (fq.out_inst_o !== 32'h0000_0413) $display("FAIL nommu_inst: got %h want 00000413", fq.out_inst_o); else n_pass++;
    n_checks++; if (fq.out_rvc_o !== 1'b0) $display("FAIL nommu_rvc: got %0h want 0", fq.out_rvc_o); else n_pass++;
    n_checks++; if (fq.out_next_pc_o !== 32'h8000_0004) $display("FAIL nommu_next_pc: got %h want 80000004", fq.out_next_pc_o); else n_pass++;
    n_checks++; if (fq.out_pf_o !== 1'b0) $display("FAIL nommu_pf: got %0h want 0", fq.out_pf_o); else n_pass++;
    n_checks++; if (fq.busy_o !== 1'b0) $display("FAIL nommu_busy: got %0h want 0", fq.busy_o); else n_pass++;
    fq.out_ready_i = 1;
    step();
    fq.out_ready_i = 0;
    n_checks++; if (fq.out_valid_o !== 1'b0) $display("FAIL nommu_popped: got %0h want 0", fq.out_valid_o); else n_pass++;
  endtask

  task automatic test_mmu();
    fq.mmu_en_i = 1; fq.pc_i = 32'h0040_0002; fq.pc_valid_i = 1;
    step();
    fq.pc_valid_i = 0; fq.mmu_en_i = 0;
    n_checks++; if (fq.xlate_req_o !== 1'b1) $display("FAIL mmu_xlate_req: got %0h want 1", fq.xlate_req_o); else n_pass++;
    n_checks++; if (fq.xlate_vaddr_o !== 32'h0040_0002) $display("FAIL mmu_vaddr: got %h want 00400002", fq.xlate_vaddr_o); else n_pass++;
    n_checks++; if (fq.mem_req_o !== 1'b0) $display("FAIL mmu_mem_early: got %0h want 0", fq.mem_req_o); else n_pass++;
    fq.xlate_resp_valid_i = 1; fq.xlate_paddr_i = 32'h8020_0002; fq.xlate_fault_i = 0;
    step();
    fq.xlate_resp_valid_i = 0;
    n_checks++; if (fq.mem_req_o !== 1'b1) $display("FAIL mmu_mem_req: got %0h want 1", fq.mem_req_o); else n_pass++;
    n_checks++; if (fq.mem_addr_o !== 32'h8020_0002) $display("FAIL mmu_mem_addr: got %h want 80200002", fq.mem_addr_o); else n_pass++;
    n_checks++; if (fq.xlate_req_o !== 1'b0) $display("FAIL mmu_xlate_done: got %0h want 0", fq.xlate_req_o); else n_pass++;
    fq.mem_rvalid_i = 1; fq.mem_rdata_i = 32'h0000_4501;
    step();
    fq.mem_rvalid_i = 0;
    n_checks++; if (fq.out_valid_o !== 1'b1) $display("FAIL mmu_valid: got %0h want 1", fq.out_valid_o); else n_pass++;
    n_checks++; if (fq.out_pc_o !== 32'h0040_0002) $display("FAIL mmu_pc: got %h want 00400002", fq.out_pc_o); else n_pass++;
    n_checks++; if (fq.out_rvc_o !== 1'b1) $display("FAIL mmu_rvc: got %0h want 1", fq.out_rvc_o); else n_pass++;
    n_checks++; if (fq.out_next_pc_o !== 32'h0040_0004) $display("FAIL mmu_next_pc: got %h want 00400004", fq.out_next_pc_o); else n_pass++;
    fq.out_ready_i = 1;
    step();
    fq.out_ready_i = 0;
  endtask

  task automatic test_fault();
    fq.mmu_en_i = 1; fq.pc_i = 32'h0000_1000; fq.pc_valid_i = 1;
    step();
    fq.pc_valid_i = 0;
    n_checks++; if (fq.mem_req_o !== 1'b0) $display("FAIL fault_mem_req_x: got %0h want 0", fq.mem_req_o); else n_pass++;
    fq.xlate_resp_valid_i = 1; fq.xlate_fault_i = 1; fq.xlate_paddr_i = 32'hDEAD_BEE0;
    step();
    fq.xlate_resp_valid_i = 0; fq.xlate_fault_i = 0;
    n_checks++; if (fq.mem_req_o !== 1'b0) $display("FAIL fault_mem_req: got %0h want 0", fq.mem_req_o); else n_pass++;
    n_checks++; if (fq.busy_o !== 1'b0) $display("FAIL fault_busy: got %0h want 0", fq.busy_o); else n_pass++;
    n_checks++; if (fq.out_valid_o !== 1'b1) $display("FAIL fault_valid: got %0h want 1", fq.out_valid_o); else n_pass++;
    n_checks++; if (fq.out_pf_o !== 1'b1) $display("FAIL fault_pf: got %0h want 1", fq.out_pf_o); else n_pass++;
    n_checks++; if (fq.out_inst_o !== 32'h0) $display("FAIL fault_inst: got %h want 0", fq.out_inst_o); else n_pass++;
    n_checks++; if (fq.out_rvc_o !== 1'b0) $display("FAIL fault_rvc: got %0h want 0", fq.out_rvc_o); else n_pass++;
    n_checks++; if (fq.out_next_pc_o !== 32'h0000_1004) $display("FAIL fault_next_pc: got %h want 00001004", fq.out_next_pc_o); else n_pass++;
    fq.out_ready_i = 1;
    step();
    fq.out_ready_i = 0;
    n_checks++; if (fq.out_valid_o !== 1'b0) $display("FAIL fault_single: got %0h want 0", fq.out_valid_o); else n_pass++;
  endtask

  task automatic test_full();
    logic [31:0] exp_pcs [3];
    exp_pcs[0] = 32'h108; exp_pcs[1] = 32'h10C; exp_pcs[2] = 32'h200;
    fq.out_ready_i = 0; fq.mmu_en_i = 0;
    for (int i = 0; i < DEPTH; i++) begin
      fq.pc_i = 32'h100 + 32'(4 * i); fq.pc_valid_i = 1;
      step();
      fq.pc_valid_i = 0; fq.mem_rvalid_i = 1; fq.mem_rdata_i = 32'h0000_0013;
      step();
      fq.mem_rvalid_i = 0;
    end
    n_checks++; if (fq.pc_ready_o !== 1'b0) $display("FAIL full_pc_ready: got %0h want 0", fq.pc_ready_o); else n_pass++;
    n_checks++; if (fq.out_pc_o !== 32'h100) $display("FAIL full_head: got %h want 100", fq.out_pc_o); else n_pass++;
    fq.pc_i = 32'h999; fq.pc_valid_i = 1;
    step();
    fq.pc_valid_i = 0;
    n_checks++; if (fq.busy_o !== 1'b0) $display("FAIL full_no_accept: got %0h want 0", fq.busy_o); else n_pass++;
    fq.out_ready_i = 1;
    step();
    fq.out_ready_i = 0;
    n_checks++; if (fq.pc_ready_o !== 1'b1) $display("FAIL full_pop_ready: got %0h want 1", fq.pc_ready_o); else n_pass++;
    n_checks++; if (fq.out_pc_o !== 32'h104) $display("FAIL full_pop_head: got %h want 104", fq.out_pc_o); else n_pass++;
    fq.pc_i = 32'h200; fq.pc_valid_i = 1;
    step();
    fq.pc_valid_i = 0; fq.mem_rvalid_i = 1; fq.mem_rdata_i = 32'h0000_0013; fq.out_ready_i = 1;
    step();
    fq.mem_rvalid_i = 0; fq.out_ready_i = 0;
    n_checks++; if (fq.pc_ready_o !== 1'b1) $display("FAIL pushpop_ready: got %0h want 1", fq.pc_ready_o); else n_pass++;
    for (int i = 0; i < 3; i++) begin
      n_checks++; if (fq.out_valid_o !== 1'b1) $display("FAIL drain_valid[%0d]: got %0h want 1", i, fq.out_valid_o); else n_pass++;
      n_checks++; if (fq.out_pc_o !== exp_pcs[i]) $display("FAIL drain_pc[%0d]: got %h want %h", i, fq.out_pc_o, exp_pcs[i]); else n_pass++;
      fq.out_ready_i = 1;
      step();
      fq.out_ready_i = 0;
    end
    n_checks++; if (fq.out_valid_o !== 1'b0) $display("FAIL drain_empty: got %0h want 0", fq.out_valid_o); else n_pass++;
  endtask

  task automatic test_flush();
    fq.mmu_en_i = 0; fq.out_ready_i = 0;
    fq.pc_i = 32'h2F0; fq.pc_valid_i = 1;
    step();
    fq.pc_valid_i = 0; fq.mem_rvalid_i = 1; fq.mem_rdata_i = 32'h13;
    step();
    fq.mem_rvalid_i = 0;
    fq.pc_i = 32'h300; fq.pc_valid_i = 1;
    step();
    fq.pc_valid_i = 0; fq.flush_i = 1;        // cycle F, FSM in MEM
    n_checks++; if (fq.pc_ready_o !== 1'b0) $display("FAIL flush_pc_ready: got %0h want 0", fq.pc_ready_o); else n_pass++;
    step();
    fq.flush_i = 0;                           // F+1
    n_checks++; if (fq.busy_o !== 1'b1) $display("FAIL kill_busy: got %0h want 1", fq.busy_o); else n_pass++;
    n_checks++; if (fq.mem_req_o !== 1'b1) $display("FAIL kill_mem_req: got %0h want 1", fq.mem_req_o); else n_pass++;
    n_checks++; if (fq.mem_addr_o !== 32'h300) $display("FAIL kill_mem_addr: got %h want 300", fq.mem_addr_o); else n_pass++;
    n_checks++; if (fq.out_valid_o !== 1'b0) $display("FAIL flush_empty: got %0h want 0", fq.out_valid_o); else n_pass++;
    step();
    fq.flush_i = 1;                           // F+2, flush while killing
    step();
    fq.flush_i = 0;                           // F+3
    n_checks++; if (fq.busy_o !== 1'b1) $display("FAIL kill_hold_busy: got %0h want 1", fq.busy_o); else n_pass++;
    n_checks++; if (fq.mem_req_o !== 1'b1) $display("FAIL kill_hold_req: got %0h want 1", fq.mem_req_o); else n_pass++;
    fq.mem_rvalid_i = 1; fq.mem_rdata_i = 32'h13;
    step();
    fq.mem_rvalid_i = 0;
    n_checks++; if (fq.busy_o !== 1'b0) $display("FAIL kill_done_busy: got %0h want 0", fq.busy_o); else n_pass++;
    n_checks++; if (fq.out_valid_o !== 1'b0) $display("FAIL kill_dropped: got %0h want 0", fq.out_valid_o); else n_pass++;
    n_checks++; if (fq.pc_ready_o !== 1'b1) $display("FAIL kill_idle_ready: got %0h want 1", fq.pc_ready_o); else n_pass++;
    // Response in the flush cycle itself.
    fq.pc_i = 32'h400; fq.pc_valid_i = 1;
    step();
    fq.pc_valid_i = 0; fq.flush_i = 1; fq.mem_rvalid_i = 1;
    step();
    fq.flush_i = 0; fq.mem_rvalid_i = 0;
    n_checks++; if (fq.busy_o !== 1'b0) $display("FAIL flush_resp_busy: got %0h want 0", fq.busy_o); else n_pass++;
    n_checks++; if (fq.out_valid_o !== 1'b0) $display("FAIL flush_resp_drop: got %0h want 0", fq.out_valid_o); else n_pass++;
    // Flush during translation keeps xlate_req open.
    fq.mmu_en_i = 1; fq.pc_i = 32'h500; fq.pc_valid_i = 1;
    step();
    fq.pc_valid_i = 0; fq.flush_i = 1;
    step();
    fq.flush_i = 0;
    n_checks++; if (fq.xlate_req_o !== 1'b1) $display("FAIL kill_x_req: got %0h want 1", fq.xlate_req_o); else n_pass++;
    n_checks++; if (fq.mem_req_o !== 1'b0) $display("FAIL kill_x_mem: got %0h want 0", fq.mem_req_o); else n_pass++;
    fq.xlate_resp_valid_i = 1; fq.xlate_paddr_i = 32'h9000;
    step();
    fq.xlate_resp_valid_i = 0;
    n_checks++; if (fq.busy_o !== 1'b0) $display("FAIL kill_x_busy: got %0h want 0", fq.busy_o); else n_pass++;
    n_checks++; if (fq.mem_req_o !== 1'b0) $display("FAIL kill_x_no_mem: got %0h want 0", fq.mem_req_o); else n_pass++;
  endtask

  task automatic test_wrap_reset();
    fq.mmu_en_i = 0; fq.out_ready_i = 0;
    fq.pc_i = 32'hFFFF_FFFE; fq.pc_valid_i = 1;
    step();
    fq.pc_valid_i = 0; fq.mem_rvalid_i = 1; fq.mem_rdata_i = 32'h0000_0001;
    step();
    fq.mem_rvalid_i = 0;
    n_checks++; if (fq.out_rvc_o !== 1'b1) $display("FAIL wrap_rvc: got %0h want 1", fq.out_rvc_o); else n_pass++;
    n_checks++; if (fq.out_next_pc_o !== 32'h0) $display("FAIL wrap_next_pc: got %h want 0", fq.out_next_pc_o); else n_pass++;
    fq.mmu_en_i = 1; fq.pc_i = 32'h1234_5678; fq.pc_valid_i = 1;
    step();
    fq.pc_valid_i = 0;
    n_checks++; if (fq.xlate_req_o !== 1'b1) $display("FAIL rst_pre_xlate: got %0h want 1", fq.xlate_req_o); else n_pass++;
    #1 rst_n = 1'b0;
    #1;
    n_checks++; if (fq.xlate_req_o !== 1'b0) $display("FAIL rst_xlate_req: got %0h want 0", fq.xlate_req_o); else n_pass++;
    n_checks++; if (fq.xlate_vaddr_o !== '0) $display("FAIL rst_vaddr: got %h want 0", fq.xlate_vaddr_o); else n_pass++;
    n_checks++; if (fq.mem_addr_o !== '0) $display("FAIL rst_mem_addr: got %h want 0", fq.mem_addr_o); else n_pass++;
    n_checks++; if (fq.busy_o !== 1'b0) $display("FAIL rst_busy: got %0h want 0", fq.busy_o); else n_pass++;
    n_checks++; if (fq.out_valid_o !== 1'b0) $display("FAIL rst_out_valid: got %0h want 0", fq.out_valid_o); else n_pass++;
    n_checks++; if (fq.out_pc_o !== '0) $display("FAIL rst_out_pc: got %h want 0", fq.out_pc_o); else n_pass++;
    n_checks++; if (fq.out_inst_o !== '0) $display("FAIL rst_out_inst: got %h want 0", fq.out_inst_o); else n_pass++;
    n_checks++; if (fq.out_next_pc_o !== '0) $display("FAIL rst_next_pc: got %h want 0", fq.out_next_pc_o); else n_pass++;
    @(posedge clk);
    #1 rst_n = 1'b1;
    fq.xlate_resp_valid_i = 1; fq.xlate_paddr_i = 32'h8000_0000; fq.xlate_fault_i = 0;
    step();
    fq.xlate_resp_valid_i = 0;
    n_checks++; if (fq.busy_o !== 1'b0) $display("FAIL stale_resp_busy: got %0h want 0", fq.busy_o); else n_pass++;
    n_checks++; if (fq.mem_req_o !== 1'b0) $display("FAIL stale_resp_mem: got %0h want 0", fq.mem_req_o); else n_pass++;
    n_checks++; if (fq.out_valid_o !== 1'b0) $display("FAIL stale_resp_push: got %0h want 0", fq.out_valid_o); else n_pass++;
  endtask

  // Randomized traffic against a transaction-level model: one fetch at a time,
  // completed entries held in plain queues in arrival order.
  task automatic test_random();
    logic [31:0] m_pc [$];
    logic [31:0] m_inst [$];
    logic        m_pf [$];
    bit          inflight;
    bit          in_xlate;
    int          delay;
    logic [31:0] p_pc, p_paddr, p_data;
    bit          p_fault;
    bit          exp_valid, exp_ready, exp_rvc;
    logic [31:0] exp_next;
    inflight = 0; in_xlate = 0; delay = 0;
    p_pc = '0; p_paddr = '0; p_fault = 0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      exp_valid = (m_pc.size() != 0);
      exp_ready = !inflight && (m_pc.size() < DEPTH);
      n_checks++; if (fq.out_valid_o !== exp_valid) $display("FAIL rnd_valid@%0d: got %0h want %0h", cyc, fq.out_valid_o, exp_valid); else n_pass++;
      n_checks++; if (fq.pc_ready_o !== exp_ready) $display("FAIL rnd_ready@%0d: got %0h want %0h", cyc, fq.pc_ready_o, exp_ready); else n_pass++;
      n_checks++; if (fq.busy_o !== inflight) $display("FAIL rnd_busy@%0d: got %0h want %0h", cyc, fq.busy_o, inflight); else n_pass++;
      n_checks++; if (fq.xlate_req_o !== (inflight && in_xlate)) $display("FAIL rnd_xreq@%0d: got %0h want %0h", cyc, fq.xlate_req_o, inflight && in_xlate); else n_pass++;
      n_checks++; if (fq.mem_req_o !== (inflight && !in_xlate)) $display("FAIL rnd_mreq@%0d: got %0h want %0h", cyc, fq.mem_req_o, inflight && !in_xlate); else n_pass++;
      if (inflight && in_xlate) begin
        n_checks++; if (fq.xlate_vaddr_o !== p_pc) $display("FAIL rnd_vaddr@%0d: got %h want %h", cyc, fq.xlate_vaddr_o, p_pc); else n_pass++;
      end
      if (inflight && !in_xlate) begin
        n_checks++; if (fq.mem_addr_o !== p_paddr) $display("FAIL rnd_maddr@%0d: got %h want %h", cyc, fq.mem_addr_o, p_paddr); else n_pass++;
      end
      if (exp_valid) begin
        exp_rvc  = (m_inst[0][1:0] != 2'b11) && !m_pf[0];
        exp_next = m_pc[0] + (exp_rvc ? 32'd2 : 32'd4);
        n_checks++; if (fq.out_pc_o !== m_pc[0]) $display("FAIL rnd_pc@%0d: got %h want %h", cyc, fq.out_pc_o, m_pc[0]); else n_pass++;
        n_checks++; if (fq.out_inst_o !== m_inst[0]) $display("FAIL rnd_inst@%0d: got %h want %h", cyc, fq.out_inst_o, m_inst[0]); else n_pass++;
        n_checks++; if (fq.out_pf_o !== m_pf[0]) $display("FAIL rnd_pf@%0d: got %0h want %0h", cyc, fq.out_pf_o, m_pf[0]); else n_pass++;
        n_checks++; if (fq.out_rvc_o !== exp_rvc) $display("FAIL rnd_rvc@%0d: got %0h want %0h", cyc, fq.out_rvc_o, exp_rvc); else n_pass++;
        n_checks++; if (fq.out_next_pc_o !== exp_next) $display("FAIL rnd_next@%0d: got %h want %h", cyc, fq.out_next_pc_o, exp_next); else n_pass++;
      end

      // Drive this cycle's inputs.
      fq.pc_valid_i = 0; fq.xlate_resp_valid_i = 0; fq.xlate_fault_i = 0; fq.mem_rvalid_i = 0;
      fq.out_ready_i = 1'($urandom_range(0, 1));
      fq.mmu_en_i    = 1'($urandom_range(0, 1));
      fq.pc_valid_i  = ($urandom_range(0, 3) != 0);
      fq.pc_i        = $urandom & 32'hFFFF_FFFE;
      if (exp_valid && fq.out_ready_i) begin
        void'(m_pc.pop_front()); void'(m_inst.pop_front()); void'(m_pf.pop_front());
      end
      if (inflight) begin
        if (delay != 0) begin
          delay--;
        end else if (in_xlate) begin
          fq.xlate_resp_valid_i = 1; fq.xlate_paddr_i = p_paddr; fq.xlate_fault_i = p_fault;
          if (p_fault) begin
            m_pc.push_back(p_pc); m_inst.push_back(32'h0); m_pf.push_back(1'b1);
            inflight = 0;
          end else begin
            in_xlate = 0;
            delay = $urandom_range(0, 3);
          end
        end else begin
          p_data = $urandom;
          fq.mem_rvalid_i = 1; fq.mem_rdata_i = p_data;
          m_pc.push_back(p_pc); m_inst.push_back(p_data); m_pf.push_back(1'b0);
          inflight = 0;
        end
      end else if (fq.pc_valid_i && exp_ready) begin
        inflight = 1;
        in_xlate = fq.mmu_en_i;
        p_pc     = fq.pc_i;
        p_paddr  = fq.mmu_en_i ? $urandom : fq.pc_i;
        p_fault  = fq.mmu_en_i && ($urandom_range(0, 3) == 0);
        delay    = $urandom_range(0, 3);
      end
      step();
    end
    fq.pc_valid_i = 0; fq.xlate_resp_valid_i = 0; fq.mem_rvalid_i = 0; fq.out_ready_i = 0;
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    test_reset();
    test_nommu();
    test_mmu();
    test_fault();
    test_full();
    test_flush();
    test_wrap_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/ifu_fetch_queue.md
IFU_FETCH_QUEUE -- requirements
Module: ifu_fetch_queue

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- XLEN, 32, address/data width.
- FQ_DEPTH, 4, fetch-queue entries; power of two, >=2.
REQ-002 Ports (name  direction  width  meaning):
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- flush_i  in  1  redirect; kill everything in flight.
- pc_i  in  XLEN  fetch virtual PC.
- pc_valid_i  in  1  fetch request.
- pc_ready_o  out  1  request accepted when both high.
- mmu_en_i  in  1  translation enabled.
- xlate_req_o  out  1  translation request.
- xlate_vaddr_o  out  XLEN  address to translate.
- xlate_resp_valid_i  in  1  translation done.
- xlate_paddr_i  in  XLEN  physical address.
- xlate_fault_i  in  1  instruction page fault; qualified by xlate_resp_valid_i.
- mem_req_o  out  1  instruction read request.
- mem_addr_o  out  XLEN  physical read address.
- mem_rvalid_i  in  1  read data valid; completes the request.
- mem_rdata_i  in  32  instruction word.
- out_valid_o  out  1  queue head valid.
- out_ready_i  in  1  downstream pops head when both high.
- out_pc_o  out  XLEN  head PC.
- out_inst_o  out  32  head instruction.
- out_rvc_o  out  1  head is compressed.
- out_next_pc_o  out  XLEN  sequential successor PC.
- out_pf_o  out  1  head carries instruction page fault.
- busy_o  out  1  FSM not IDLE.

Function
REQ-003 The FSM SHALL have states IDLE, XLATE, MEM, KILL.
REQ-004 pc_ready_o SHALL be 1 only when state==IDLE, count<FQ_DEPTH and flush_i==0.
REQ-005 On acceptance, the PC SHALL be registered; next state XLATE if mmu_en_i==1, else MEM with physical address = pc_i.
REQ-006 XLATE: xlate_req_o=1, xlate_vaddr_o=registered PC, held until xlate_resp_valid_i.
REQ-007 XLATE response without fault: latch xlate_paddr_i; go to MEM next cycle.
REQ-008 XLATE response with fault: push {pc, inst=0, pf=1} into the queue; go to IDLE; no memory request.
REQ-009 MEM: mem_req_o=1, mem_addr_o=physical address, held until mem_rvalid_i.
REQ-010 On mem_rvalid_i: push {pc, mem_rdata_i, pf=0}; go to IDLE.
REQ-011 Latency with mmu_en_i=0 and a same-cycle response: accept at cycle N, mem_req_o at N+1, head valid at N+2 when rvalid arrives at N+1.
REQ-012 Queue: circular FIFO with FQ_DEPTH entries, wrap-around pointers and a count of width clog2(FQ_DEPTH)+1.
REQ-013 Push and pop in the same cycle SHALL leave count unchanged.
REQ-014 Push can never overflow; this is guaranteed by REQ-004 with a single outstanding fetch.
REQ-015 out_valid_o SHALL equal (count!=0); head outputs come from the head entry, registered storage only.
REQ-016 out_rvc_o SHALL equal (out_inst_o[1:0]!=2'b11) && !out_pf_o.
REQ-017 out_next_pc_o SHALL be out_pc_o+2 if out_rvc_o, else out_pc_o+4, computed modulo 2^XLEN.
REQ-018 flush_i SHALL empty the queue and drop any same-cycle push.
- IDLE: stay in IDLE.
- XLATE or MEM: go to KILL.
- If the pending response arrives in the flush cycle itself, it is discarded and the FSM goes to IDLE.
REQ-019 KILL: keep the outstanding request (xlate_req_o or mem_req_o) asserted until its response, discard the response, go to IDLE.
REQ-020 flush_i during KILL SHALL have no additional effect.
REQ-021 mmu_en_i SHALL be sampled only at acceptance; later changes do not affect an in-flight fetch.
REQ-022 busy_o SHALL be 1 in every state except IDLE.

Reset
REQ-023 rst_n low SHALL asynchronously force:
- state=IDLE; queue pointers and count=0.
- xlate_req_o, mem_req_o, out_valid_o, out_pf_o and busy_o = 0.
- All address and data outputs = 0.
REQ-024 Reset mid-fetch SHALL abandon the fetch; a response arriving after reset release SHALL be ignored in IDLE.

Verification
REQ-025 The bench SHALL cover these scenarios:
- mmu_en_i=0, pc_i=0x8000_0000, rvalid next cycle with rdata=0x0000_0413 -> head pc=0x8000_0000, rvc=0, next_pc=0x8000_0004, pf=0, valid at cycle N+2.
- mmu_en_i=1, vaddr 0x0040_0002 -> paddr 0x8020_0002, rdata=0x0000_4501 -> mem_addr_o=0x8020_0002, rvc=1, next_pc=0x0040_0004.
- mmu_en_i=1, xlate_fault_i=1 at pc 0x1000 -> single entry pf=1, inst=0, next_pc=0x1004, mem_req_o never asserted.
- out_ready_i=0, FQ_DEPTH fetches completed -> count=4, pc_ready_o=0; pop one -> pc_ready_o=1 next cycle; simultaneous push/pop keeps count.
- flush_i while in MEM, rvalid three cycles later -> queue empty, state KILL until rvalid, response not pushed, then IDLE.
- pc_i=0xFFFF_FFFE, rdata=0x0001 -> next_pc=0x0000_0000 (wrap); rst_n pulse mid-XLATE -> all outputs 0 immediately.
